calc_control_unit: RTL and testbench

Sequencing controller that sits directly upstream of the 8-bit arithmetic unit in the four-function calculator. It accepts an operation request, registers the operands, and issues the single-cycle load and AddSub controls the arithmetic unit needs for add and subtract. It executes multiply (shift-add) and divide (restoring) itself over 8 iterations. It reports completion, busy and divide-by-zero status to the top-level display/keypad logic.

---
 rtl/calc_control_unit.sv | 200 ++++++++++++++++++++
 tb/tb_calc_control_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_control_unit.sv
// Sequencing controller for the four-function calculator: issues load/AddSub strobes
// to the arithmetic unit for add/sub and runs 8-step shift-add multiply and restoring divide locally.
module calc_control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [7:0]  AOut,
  output logic [7:0]  BOut,
  output logic        LoadA,
  output logic        LoadB,
  output logic        LoadR,
  output logic        AddSub,
  output logic [15:0] Result,
  output logic        ResSel,
  output logic        Busy,
  output logic        Done,
  output logic        Halt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_MUL,
    S_DIV,
    S_DONE,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  state_e      state_q,  state_d;
  op_e         op_q,     op_d;
  logic [7:0]  a_q,      a_d;
  logic [7:0]  b_q,      b_d;
  logic        addsub_q, addsub_d;
  logic        ressel_q, ressel_d;
  logic [15:0] result_q, result_d;
  logic [15:0] acc_q,    acc_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [7:0]  dvd_q,    dvd_d;
  logic [7:0]  rem_q,    rem_d;
  logic [2:0]  cnt_q,    cnt_d;

  logic [15:0] mul_addend;
  logic [8:0]  div_shift;
  logic [8:0]  div_trial;

  // Multiplicand weighted by the current iteration; multiplier bits are consumed LSB first.
  assign mul_addend = {8'h00, a_q} << cnt_q;

  // Restoring step: the partial remainder always stays below the divisor, so 9 bits cannot overflow.
  assign div_shift  = {rem_q, dvd_q[7]};
  assign div_trial  = div_shift - {1'b0, b_q};

  // NOTE: register every state bit, including the iteration datapath, on reset so an abandoned
  // operation can never leak partial values into the next one.
  // NOTE: sequential state uses non-blocking assignments so all registers update from the same snapshot.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      addsub_q <= 1'b0;
      ressel_q <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      addsub_q <= addsub_d;
      ressel_q <= ressel_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    addsub_d = addsub_q;
    ressel_d = ressel_q;
    result_d = result_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      // A Start in HALT takes the same capture path as IDLE; Halt drops as the state leaves HALT.
      S_IDLE, S_HALT: begin
        if (Start) begin
          op_d     = op_e'(Op);
          a_d      = A;
          b_d      = B;
          addsub_d = (op_e'(Op) == OP_SUB);
          ressel_d = Op[1];
          result_d = '0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        unique case (op_q)
          OP_ADD, OP_SUB: state_d = S_EXEC;
          OP_MUL: begin
            acc_d    = '0;
            cnt_d    = '0;
            mplier_d = b_q;
            state_d  = S_MUL;
          end
          OP_DIV: begin
            if (b_q == 8'h00) begin
              result_d = '0;
              state_d  = S_HALT;
            end else begin
              rem_d   = '0;
              cnt_d   = '0;
              dvd_d   = a_q;
              state_d = S_DIV;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_EXEC: state_d = S_DONE;

      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mul_addend;
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          result_d = acc_d;
          state_d  = S_DONE;
        end
      end

      // The dividend register doubles as the quotient: its MSB shifts out as a quotient bit shifts in.
      S_DIV: begin
        if (!div_trial[8]) begin
          rem_d = div_trial[7:0];
          dvd_d = {dvd_q[6:0], 1'b1};
        end else begin
          rem_d = div_shift[7:0];
          dvd_d = {dvd_q[6:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          result_d = {rem_d, dvd_d};
          state_d  = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs are decoded from the state register only, so inputs never reach them combinationally.
  assign LoadA  = (state_q == S_LOAD);
  assign LoadB  = (state_q == S_LOAD);
  assign LoadR  = (state_q == S_EXEC);
  assign Done   = (state_q == S_DONE);
  assign Halt   = (state_q == S_HALT);
  assign Busy   = !((state_q == S_IDLE) || (state_q == S_HALT));

  assign AOut   = a_q;
  assign BOut   = b_q;
  assign AddSub = addsub_q;
  assign ResSel = ressel_q;
  assign Result = result_q;

endmodule

// File: tb/tb_calc_control_unit.sv
// Self-checking bench for calc_control_unit: directed scenarios plus randomized operations
// checked against arithmetic expectations and the documented cycle latencies.
module tb_calc_control_unit;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [7:0]  AOut;
  logic [7:0]  BOut;
  logic        LoadA;
  logic        LoadB;
  logic        LoadR;
  logic        AddSub;
  logic [15:0] Result;
  logic        ResSel;
  logic        Busy;
  logic        Done;
  logic        Halt;

  int n_checks = 0;
  int n_pass   = 0;

  calc_control_unit dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .AOut   (AOut),
    .BOut   (BOut),
    .LoadA  (LoadA),
    .LoadB  (LoadB),
    .LoadR  (LoadR),
    .AddSub (AddSub),
    .Result (Result),
    .ResSel (ResSel),
    .Busy   (Busy),
    .Done   (Done),
    .Halt   (Halt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [47:0] all_outs();
    return 48'({AOut, BOut, Result, LoadA, LoadB, LoadR, AddSub, ResSel, Busy, Done, Halt});
  endfunction

  // Present a request for one edge, then scramble the inputs so only captured values can explain the outputs.
  task automatic launch(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    step();
    Start = 1'b0;
    Op    = 2'($urandom);
    A     = 8'($urandom);
    B     = 8'($urandom);
  endtask

  // Full operation from a state that accepts Start; expectations come from plain arithmetic.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
    int          lat;
    int          busy_gaps;
    int          exp_lat;
    logic [15:0] exp_res;
    exp_lat = op[1] ? 10 : 3;
    case (op)
      2'b10:   exp_res = 16'(a) * 16'(b);
      2'b11:   exp_res = {8'(a % b), 8'(a / b)};
      default: exp_res = 16'h0000;
    endcase
    launch(op, a, b);
    check({tag, " c1 strobes"}, 48'({LoadA, LoadB, LoadR, Halt, Busy}), 48'(5'b11001));
    check({tag, " c1 operands"}, 48'({AOut, BOut}), 48'({a, b}));
    check({tag, " c1 addsub/ressel"}, 48'({AddSub, ResSel}), 48'({op == 2'b01, op[1]}));
    check({tag, " c1 result cleared"}, 48'(Result), 48'h0);
    lat = 1;
    busy_gaps = 0;
    while (!Done && lat < 40) begin
      if (!Busy) busy_gaps++;
      step();
      lat++;
    end
    check({tag, " done latency"}, 48'(lat), 48'(exp_lat));
    check({tag, " result"}, 48'(Result), 48'(exp_res));
    check({tag, " done flags"}, 48'({LoadA, LoadB, LoadR, Busy, Halt, ResSel, AddSub}),
          48'({4'b0001, 1'b0, op[1], op == 2'b01}));
    check({tag, " busy gaps"}, 48'(busy_gaps), 48'h0);
    check({tag, " operands held"}, 48'({AOut, BOut}), 48'({a, b}));
    step();
    check({tag, " after done"}, 48'({Done, Busy, Result}), 48'({2'b00, exp_res}));
  endtask

  task automatic div0_op(input logic [7:0] a, input string tag);
    launch(2'b11, a, 8'h00);
    check({tag, " c1 load"}, 48'({LoadA, LoadB, Halt, Busy}), 48'(4'b1101));
    step();
    check({tag, " c2 halt"}, 48'({Halt, Busy, Done, ResSel, Result}), 48'({4'b1001, 16'h0000}));
    step();
    step();
    check({tag, " halt held"}, 48'({Halt, Busy, Done, LoadA, LoadR}), 48'(5'b10000));
  endtask

  initial begin
    int n_done;
    logic [1:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;

    Reset = 1'b1;
    Start = 1'b0;
    Op    = 2'b00;
    A     = 8'h00;
    B     = 8'h00;
    step();
    step();
    check("reset outputs", all_outs(), 48'h0);

    // Reset and Start together: Reset wins.
    Start = 1'b1;
    Op    = 2'b10;
    A     = 8'h11;
    B     = 8'h22;
    step();
    Reset = 1'b0;
    Start = 1'b0;
    check("reset beats start", all_outs(), 48'h0);
    step();
    check("idle after reset", 48'({Busy, LoadA, Done}), 48'h0);

    // Add, checked cycle by cycle.
    launch(2'b00, 8'd25, 8'd17);
    check("add c1", 48'({LoadA, LoadB, LoadR, AddSub, Busy, AOut, BOut}), 48'({5'b11001, 8'd25, 8'd17}));
    step();
    check("add c2", 48'({LoadA, LoadB, LoadR, AddSub, Busy, Done}), 48'(6'b001010));
    step();
    check("add c3", 48'({Done, ResSel, Busy, LoadR}), 48'(4'b1010));
    step();
    check("add c4", 48'({Busy, Done}), 48'h0);

    // Subtract, then a back-to-back multiply accepted in cycle 4.
    do_op(2'b01, 8'd5, 8'd9, "sub");
    do_op(2'b10, 8'd255, 8'd255, "mul255");
    check("mul255 product", 48'(Result), 48'h00_FE01);

    do_op(2'b11, 8'd200, 8'd7, "div200_7");
    check("div200_7 value", 48'(Result), 48'h00_041C);
    do_op(2'b11, 8'd7, 8'd200, "div7_200");
    check("div7_200 value", 48'(Result), 48'h00_0700);

    // Divide by zero, then recovery straight from HALT.
    div0_op(8'd50, "div0");
    do_op(2'b00, 8'd1, 8'd1, "add_after_halt");

    // Start pulses during MUL cycles 3..8 must be ignored.
    launch(2'b10, 8'd13, 8'd11);
    step();
    step();
    n_done = 0;
    for (int c = 3; c <= 8; c++) begin
      Start = 1'b1;
      Op    = 2'($urandom);
      A     = 8'($urandom);
      B     = 8'($urandom);
      if (Done) n_done++;
      step();
    end
    Start = 1'b0;
    check("busy start operands", 48'({AOut, BOut, Result}), 48'({8'd13, 8'd11, 16'h0000}));
    if (Done) n_done++;
    step();
    check("busy start done c10", 48'({Done, Result}), 48'({1'b1, 16'd143}));
    if (Done) n_done++;
    step();
    if (Done) n_done++;
    step();
    check("busy start single done", 48'({n_done[7:0], Busy}), 48'({8'd1, 1'b0}));

    // Reset in MUL cycle 5 abandons the operation.
    launch(2'b10, 8'd200, 8'd3);
    step();
    step();
    step();
    step();
    check("mid-op busy", 48'(Busy), 48'h1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("mid-op reset outputs", all_outs(), 48'h0);
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (Done || Busy) n_done++;
    end
    check("mid-op no done", 48'(n_done), 48'h0);
    do_op(2'b10, 8'd3, 8'd4, "mul3_4");
    check("mul3_4 value", 48'(Result), 48'd12);

    // Randomized operations with random idle gaps; zero divisors are injected occasionally.
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom);
      r_a  = 8'($urandom);
      r_b  = 8'($urandom);
      if (r_op == 2'b11 && $urandom_range(0, 4) == 0) r_b = 8'h00;
      if (r_op == 2'b11 && r_b == 8'h00) begin
        div0_op(r_a, $sformatf("rnd%0d div0", i));
      end else begin
        do_op(r_op, r_a, r_b, $sformatf("rnd%0d op%0d %0d,%0d", i, r_op, r_a, r_b));
      end
      repeat ($urandom_range(0, 2)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
